dual_input_debounce: RTL and testbench
======================================

# dual_input_debounce

Input conditioning stage for the two-key detector FSM. It takes two raw, asynchronous key/switch signals, synchronises each into the `clk` domain and debounces each channel independently. It drives the detector's `x1`/`x2` inputs with clean levels, plus a one-cycle `chg` strobe whenever the conditioned pair changes. It sits directly upstream of the FSM and shares its clock and reset.

## Interface
- `DB_CYCLES`, default 4: consecutive cycles a synchronised level must differ from the output before the output follows; legal range 1 .. 2^`CNT_W`−1.
- `CNT_W`, default 3: width of each channel's debounce counter.
- `clk`  input  1  system clock, rising-edge.
- `rstn`  input  1  reset; one clock, synchronous, active-low.
- `key1_raw`  input  1  raw channel 1, asynchronous to `clk`, may bounce.
- `key2_raw`  input  1  raw channel 2, asynchronous to `clk`, may bounce.
- `x1`  output  1  debounced channel 1 level, registered.
- `x2`  output  1  debounced channel 2 level, registered.
- `chg`  output  1  one-cycle pulse, high in the first cycle `{x1,x2}` holds a new value.

## Operation
- Per channel: 2-flop synchroniser `s1 <= raw; s2 <= s1`. Only `s2` feeds the debounce logic.
- Per-channel state machine, states STABLE and CHECK, with counter `cnt`:
  - STABLE, `s2 == x`: stay; `cnt = 0`.
  - STABLE, `s2 != x`, `DB_CYCLES == 1`: `x <= s2`; stay STABLE.
  - STABLE, `s2 != x`, `DB_CYCLES > 1`: go to CHECK; `cnt <= 1`.
  - CHECK, `s2 == x` (glitch ended): go to STABLE; `cnt <= 0`; `x` unchanged.
  - CHECK, `s2 != x`, `cnt == DB_CYCLES−1`: `x <= s2`; go to STABLE; `cnt <= 0`.
  - CHECK, `s2 != x`, otherwise: `cnt <= cnt + 1`.
- `cnt` never exceeds `DB_CYCLES−1`. No wrap is reachable for legal parameters.
- `chg <= (x1_next != x1) | (x2_next != x2)`, registered so it rises on the same edge as the output change.
  - If both channels toggle on the same edge, the result is one `chg` pulse, not two.
  - A direct 01→10 change is passed through as-is; the downstream FSM sees `10` with no intermediate value.
- Channels are fully independent. Activity on one never delays or resets the other.

## Timing
- Reset: while `rstn` is low at a rising edge, the following are cleared on that edge: `s1`, `s2`, `x1`, `x2`, `chg` = 0; both channels go to STABLE with `cnt` = 0. Reset dominates all other activity.
- Reset mid-CHECK: the partial count is discarded. After release the channel restarts from STABLE with `x` = 0.
- A raw level held high through reset produces `x` = 1 exactly `DB_CYCLES+2` edges after the first edge with `rstn` high.
- Latency: take a clean raw edge set up before edge E. The output changes on edge E+`DB_CYCLES`+1, i.e. `DB_CYCLES`+2 edges counting E. With the default this is 6 edges. `chg` is high for the cycle following that edge only.
- Rejection: an `s2` disagreement lasting fewer than `DB_CYCLES` consecutive edges never changes `x`.
- Raw pulses shorter than one clock may or may not be captured by the synchroniser. This is acceptable.

## Test plan
- **Reset:** drive `key1_raw`=`key2_raw`=1 with `rstn`=0 for 3 edges, then release → `x1`=`x2`=0 and `chg`=0 during reset. Both outputs rise together 6 edges after release, with a single 1-cycle `chg`.
- **Clean step:** `key1_raw` 0→1 before edge 10 → `x1`=1 from edge 15, `chg`=1 for exactly that cycle, `x2` unchanged.
- **Bounce rejection:** `key2_raw` toggles 1,0,1,0 every 2 cycles, then rests at 0 → `x2` and `chg` stay 0 throughout. Then hold `key2_raw`=1 → `x2` rises 6 edges after the final rise.
- **Boundary count:** a raw pulse lasting 3 cycles → no change. A raw pulse lasting exactly 4 cycles → `x1` pulses high for 4 cycles, with a `chg` pulse at each output edge.
- **Simultaneous and cross:** both raw inputs rise on the same edge → one `chg`, `{x1,x2}` goes 00→11. From `x1`=1,`x2`=0, drop key1 and raise key2 on the same edge → `{x1,x2}` goes 10→01 on a single edge with one `chg`.
- **Reset mid-CHECK:** start a key1 rise, assert `rstn`=0 on the 3rd CHECK cycle, release with the key still high → `x1`=0 at reset. `x1` rises 6 edges after release.

Source files
------------

// File: rtl/dual_input_debounce.sv
// Two-channel key conditioner: per-channel 2-flop synchroniser plus a
// STABLE/CHECK debounce FSM, with a single change strobe for the output pair.
module dual_input_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic key1_raw,
    input  logic key2_raw,
    output logic x1,
    output logic x2,
    output logic chg
);
    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0] raw;
    logic [1:0] x_reg;
    logic [1:0] x_next;
    logic       chg_reg;

    assign raw = {key2_raw, key1_raw};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic                 s1_reg;
            logic                 s2_reg;
            state_t               state_reg;
            state_t               state_next;
            logic [CNT_W-1:0]     cnt_reg;
            logic [CNT_W-1:0]     cnt_next;
            logic                 x_ch_reg;
            logic                 x_ch_next;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= raw[gi];
                    s2_reg <= s1_reg;
                end
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    state_reg <= STABLE;
                    cnt_reg   <= '0;
                    x_ch_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    x_ch_reg  <= x_ch_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    STABLE: begin
                        if (s2_reg != x_ch_reg && DB_CYCLES > 1)
                            state_next = CHECK;
                    end
                    CHECK: begin
                        if (s2_reg == x_ch_reg || cnt_reg == CNT_LAST)
                            state_next = STABLE;
                    end
                    default: state_next = STABLE;
                endcase
            end

            // Counter and level update; the level only moves on a confirmed run.
            always_comb begin
                cnt_next  = '0;
                x_ch_next = x_ch_reg;
                case (state_reg)
                    STABLE: begin
                        if (s2_reg != x_ch_reg) begin
                            if (DB_CYCLES == 1)
                                x_ch_next = s2_reg;
                            else
                                cnt_next = CNT_W'(1);
                        end
                    end
                    CHECK: begin
                        if (s2_reg != x_ch_reg) begin
                            if (cnt_reg == CNT_LAST)
                                x_ch_next = s2_reg;
                            else
                                cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                    default: cnt_next = '0;
                endcase
            end
        end
    endgenerate

    assign x_reg  = {g_chan[1].x_ch_reg,  g_chan[0].x_ch_reg};
    assign x_next = {g_chan[1].x_ch_next, g_chan[0].x_ch_next};

    // One strobe per output edge, even when both channels move together.
    always_ff @(posedge clk) begin
        if (!rstn)
            chg_reg <= 1'b0;
        else
            chg_reg <= (x_next != x_reg);
    end

    assign x1  = x_reg[0];
    assign x2  = x_reg[1];
    assign chg = chg_reg;
endmodule

// File: tb/tb_dual_input_debounce.sv
// Directed bench for dual_input_debounce: each phase drives the raw keys and
// checks {x1,x2} and chg cycle by cycle against hand-derived timing.
module tb_dual_input_debounce;
    logic clk;
    logic rstn;
    logic key1_raw;
    logic key2_raw;
    logic x1;
    logic x2;
    logic chg;

    int   n_checks;
    int   n_errors;
    logic [1:0] cur;

    dual_input_debounce #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .key1_raw (key1_raw),
        .key2_raw (key2_raw),
        .x1       (x1),
        .x2       (x2),
        .chg      (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_pair"}, {30'd0, x1, x2}, {30'd0, cur});
            chk({tag, "_chg"}, {31'd0, chg}, 32'd0);
        end
        $display("txn %s: held %0d cycles pair=%b", tag, n, cur);
    endtask

    // Raw inputs were just changed: 5 quiet edges, change on the 6th, strobe drops on the 7th.
    task automatic settle(input string tag, input logic [1:0] nxt);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk({tag, "_wait_pair"}, {30'd0, x1, x2}, {30'd0, cur});
            chk({tag, "_wait_chg"}, {31'd0, chg}, 32'd0);
        end
        tick();
        chk({tag, "_edge_pair"}, {30'd0, x1, x2}, {30'd0, nxt});
        chk({tag, "_edge_chg"}, {31'd0, chg}, 32'd1);
        cur = nxt;
        tick();
        chk({tag, "_after_pair"}, {30'd0, x1, x2}, {30'd0, cur});
        chk({tag, "_after_chg"}, {31'd0, chg}, 32'd0);
        $display("txn %s: pair -> %b", tag, cur);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cur      = 2'b00;
        rstn     = 1'b0;
        key1_raw = 1'b1;
        key2_raw = 1'b1;

        // Reset with both keys high, then both rise together after release.
        hold("reset", 3);
        rstn = 1'b1;
        settle("rst_release", 2'b11);
        key1_raw = 1'b0;
        key2_raw = 1'b0;
        settle("both_fall", 2'b00);

        // Clean step on key1 only.
        key1_raw = 1'b1;
        settle("step_up", 2'b10);
        key1_raw = 1'b0;
        settle("step_down", 2'b00);

        // Bounce on key2 every 2 cycles is rejected.
        key2_raw = 1'b1; hold("bounce_a", 2);
        key2_raw = 1'b0; hold("bounce_b", 2);
        key2_raw = 1'b1; hold("bounce_c", 2);
        key2_raw = 1'b0; hold("bounce_rest", 8);
        key2_raw = 1'b1;
        settle("bounce_final", 2'b01);
        key2_raw = 1'b0;
        settle("key2_down", 2'b00);

        // 3-cycle raw pulse is rejected.
        key1_raw = 1'b1; hold("pulse3_hi", 3);
        key1_raw = 1'b0; hold("pulse3_lo", 10);

        // 4-cycle raw pulse passes as a 4-cycle output pulse.
        key1_raw = 1'b1; hold("pulse4_hi", 4);
        key1_raw = 1'b0; hold("pulse4_wait", 1);
        tick();
        chk("pulse4_rise_pair", {30'd0, x1, x2}, 32'b10);
        chk("pulse4_rise_chg", {31'd0, chg}, 32'd1);
        cur = 2'b10;
        hold("pulse4_high", 3);
        tick();
        chk("pulse4_fall_pair", {30'd0, x1, x2}, 32'b00);
        chk("pulse4_fall_chg", {31'd0, chg}, 32'd1);
        cur = 2'b00;
        hold("pulse4_idle", 3);

        // Simultaneous rise, then a direct 10 -> 01 cross-over.
        key1_raw = 1'b1; key2_raw = 1'b1;
        settle("simul_up", 2'b11);
        key2_raw = 1'b0;
        settle("k2_drop", 2'b10);
        key1_raw = 1'b0; key2_raw = 1'b1;
        settle("cross", 2'b01);
        key2_raw = 1'b0;
        settle("cross_clear", 2'b00);

        // Reset while key1 is partway through its check window.
        key1_raw = 1'b1; hold("midchk_pre", 4);
        rstn = 1'b0;
        tick();
        chk("midchk_rst_pair", {30'd0, x1, x2}, 32'b00);
        chk("midchk_rst_chg", {31'd0, chg}, 32'd0);
        rstn = 1'b1;
        settle("midchk_release", 2'b10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
